// File: rtl/user_wb_gate.sv
// user_wb_gate
//   Wishbone request gate between the Caravel management bus and the
//   user-area wait-state BRAM slave. Cycles inside the user address window
//   are registered and forwarded to the slave, and the slave's data/ack is
//   returned upstream. Cycles outside the window are answered locally with
//   zero data and counted as errors.
//
//   Optional feature macro: USER_WB_GATE_WATCHDOG_EN
//     defined   : a watchdog ends forwarded cycles the slave never acks.
//                 The cycle completes with ERR_DATA, timeout_o pulses and
//                 err_cnt_o counts the event.
//     undefined : forwarded cycles wait for m_ack_i or a master abort.
//                 timeout_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i            clock; synchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i  upstream request from the management bus
//   wbs_ack_o, wbs_dat_o          upstream response (registered)
//   m_cyc/stb/we/sel/adr/dat_o    downstream request (registered, latched)
//   m_ack_i, m_dat_i              downstream response
//   timeout_o                     one-cycle pulse per watchdog termination
//   err_cnt_o                     saturating count of timeouts and
//                                 out-of-window cycles
module user_wb_gate #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0040_0000,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        timeout_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  // 33-bit bounds so a window reaching the top of the address space does
  // not wrap around to zero.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + {1'b0, WIN_SIZE};

  state_t      state_q, state_d;
  logic        req, in_win;
  logic        load;      // latch upstream request into m_* and start FWD
  logic        m_drop;    // release downstream cyc/stb
  logic        ack_d;     // upstream ack for the RESP cycle
  logic        cap_en;    // update wbs_dat_o
  logic [31:0] cap_dat;
  logic        err_inc;
  logic        wd_hit;
  logic        to_d;

  assign req    = wbs_cyc_i & wbs_stb_i;
  assign in_win = ({1'b0, wbs_adr_i} >= WIN_LO) && ({1'b0, wbs_adr_i} < WIN_HI);

`ifdef USER_WB_GATE_WATCHDOG_EN
  // Counts FWD cycles; cleared on accept, so it reads n-1 on the n-th
  // FWD edge and fires on the TIMEOUT-th one.
  logic [15:0] wd_cnt;

  assign wd_hit = (state_q == FWD) && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)            wd_cnt <= '0;
    else if (load)           wd_cnt <= '0;
    else if (state_q == FWD) wd_cnt <= wd_cnt + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) timeout_o <= 1'b0;
    else          timeout_o <= to_d;
  end
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next state and the strobes that drive the output registers.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    m_drop  = 1'b0;
    ack_d   = 1'b0;
    cap_en  = 1'b0;
    cap_dat = m_dat_i;
    err_inc = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (in_win) begin
            load    = 1'b1;
            state_d = FWD;
          end else begin
            // Answered locally: zero data, write data dropped.
            cap_en  = 1'b1;
            cap_dat = '0;
            err_inc = 1'b1;
            ack_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      FWD: begin
        // A slave ack on the watchdog's last cycle still counts as a
        // normal completion, so it is tested first.
        if (m_ack_i) begin
          cap_en  = 1'b1;
          m_drop  = 1'b1;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (!wbs_cyc_i) begin
          m_drop  = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          cap_en  = 1'b1;
          cap_dat = ERR_DATA;
          m_drop  = 1'b1;
          ack_d   = 1'b1;
          err_inc = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      err_cnt_o <= '0;
    end else begin
      wbs_ack_o <= ack_d;
      if (cap_en) wbs_dat_o <= cap_dat;
      if (load) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= wbs_we_i;
        m_sel_o <= wbs_sel_i;
        m_adr_o <= wbs_adr_i;
        m_dat_o <= wbs_dat_i;
      end else if (m_drop) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
      end
      if (err_inc && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_user_wb_gate.sv
// Bench for user_wb_gate. Each directed transaction writes a timeline into
// the model (the cycle its ack appears, the cycles m_cyc_o is high, when
// wbs_dat_o / err_cnt_o take new values) using the latencies stated for the
// block; a compare process checks every output against that timeline each
// cycle. Literal checks pin the latencies and values from the test plan.
module tb_user_wb_gate;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam logic [31:0] WIN  = 32'h0040_0000;
  localparam int          TMO  = 64;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i = 0;
  logic [31:0] m_dat_i = '0;
  logic        timeout_o;
  logic [7:0]  err_cnt_o;

  always #5 clk = ~clk;

  user_wb_gate #(.BASE_ADDR(BASE), .WIN_SIZE(WIN), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
  );

  // cyc_n == E at the negedge following rising edge number E.
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---- model timeline ----
  int          ack_c = -1, to_c = -1, mfrom = -1, mto = -2;
  logic [31:0] madr = '0, mdat = '0;
  logic [3:0]  msel = '0;
  logic        mwe = 1'b0;
  logic [31:0] dat_old = '0, dat_new = '0;
  bit          old_known = 1, new_known = 1;
  int          dat_from = 0;
  int          err_old = 0, err_new = 0, err_from = 0;
  int          last_ack = -1;
  bit          chk_en = 0;
  int          nchecks = 0, nerr = 0;

  function automatic int cur_err();
    return (cyc_n >= err_from) ? err_new : err_old;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic set_dat(input int from, input logic [31:0] v, input bit known);
    if (cyc_n >= dat_from) begin
      dat_old   = dat_new;
      old_known = new_known;
    end
    dat_new = v; new_known = known; dat_from = from;
  endtask

  task automatic bump_err(input int from);
    err_old  = cur_err();
    err_new  = (err_old < 255) ? err_old + 1 : 255;
    err_from = from;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      bit e_m;
      e_m = (cyc_n >= mfrom) && (cyc_n <= mto);
      chk("wbs_ack_o", 32'(wbs_ack_o), 32'(cyc_n == ack_c));
      chk("timeout_o", 32'(timeout_o), 32'(cyc_n == to_c));
      chk("m_cyc_o", 32'(m_cyc_o), 32'(e_m));
      chk("m_stb_o", 32'(m_stb_o), 32'(e_m));
      if (e_m) begin
        chk("m_adr_o", m_adr_o, madr);
        chk("m_dat_o", m_dat_o, mdat);
        chk("m_sel_o", 32'(m_sel_o), 32'(msel));
        chk("m_we_o", 32'(m_we_o), 32'(mwe));
      end
      if (cyc_n >= dat_from) begin
        if (new_known) chk("wbs_dat_o", wbs_dat_o, dat_new);
      end else if (old_known) chk("wbs_dat_o", wbs_dat_o, dat_old);
      chk("err_cnt_o", 32'(err_cnt_o), 32'(cur_err()));
      if (wbs_ack_o === 1'b1) last_ack = cyc_n;
    end
  end

  // ---- stimulus ----
  task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] d, input logic [3:0] sel);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = d; wbs_sel_i = sel;
  endtask

  task automatic drop();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  // In-window cycle; slave acks lat cycles after m_stb_o first appears.
  task automatic txn_fwd(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                         input logic [3:0] sel, input int lat, input logic [31:0] sd, output int acc);
    int a;
    a = cyc_n + 1; acc = a;
    req(adr, we, wd, sel);
    mfrom = a; mto = a + lat; madr = adr; mdat = wd; msel = sel; mwe = we;
    ack_c = a + lat + 1;
    set_dat(ack_c, sd, !we);
    while (cyc_n < a + lat) @(negedge clk);
    m_ack_i = 1; m_dat_i = sd;
    @(negedge clk);
    m_ack_i = 0; m_dat_i = $urandom; drop();
    @(negedge clk);
  endtask

  task automatic txn_oow(input logic [31:0] adr, input logic we, output int acc);
    int a;
    a = cyc_n + 1; acc = a;
    req(adr, we, 32'h1111_2222, 4'hF);
    ack_c = a;
    set_dat(a, '0, 1);
    bump_err(a);
    @(negedge clk);
    drop();
    @(negedge clk);
  endtask

`ifdef USER_WB_GATE_WATCHDOG_EN
  task automatic txn_timeout(input logic [31:0] adr, output int acc);
    int a;
    a = cyc_n + 1; acc = a;
    req(adr, 0, 32'h0, 4'hF);
    mfrom = a; mto = a + TMO - 1; madr = adr; mdat = 32'h0; msel = 4'hF; mwe = 0;
    ack_c = a + TMO; to_c = ack_c;
    set_dat(ack_c, ERRD, 1);
    bump_err(ack_c);
    while (cyc_n < ack_c) @(negedge clk);
    drop();
    @(negedge clk);
  endtask
`endif

  task automatic txn_abort(input logic [31:0] adr, input int n);
    int a;
    a = cyc_n + 1;
    req(adr, 0, 32'h0, 4'h3);
    mfrom = a; mto = a + n; madr = adr; mdat = 32'h0; msel = 4'h3; mwe = 0;
    ack_c = -1;
    while (cyc_n < a + n) @(negedge clk);
    drop();
    @(negedge clk);
  endtask

  task automatic txn_reset(input logic [31:0] adr, input int n);
    int a;
    a = cyc_n + 1;
    req(adr, 1, 32'h7777_8888, 4'hC);
    mfrom = a; mto = a + n; madr = adr; mdat = 32'h7777_8888; msel = 4'hC; mwe = 1;
    ack_c = -1;
    while (cyc_n < a + n) @(negedge clk);
    rst = 1; drop();
    set_dat(a + n + 1, '0, 1);
    err_old = cur_err(); err_new = 0; err_from = a + n + 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout at cycle %0d: got running want finished", cyc_n);
    $fatal(1, "bench time limit");
  end

  initial begin
    int acc, first_ack;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #3;
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_mcyc", 32'(m_cyc_o), 32'd0);
    chk("rst_err", 32'(err_cnt_o), 32'd0);
    @(negedge clk);

    // Read with 11-cycle slave latency.
    txn_fwd(32'h3800_0010, 0, 32'h0, 4'hF, 11, 32'h1234_5678, acc);
    #3;
    chk("rd_latency", 32'(last_ack + 1 - acc), 32'd13);
    chk("rd_data", wbs_dat_o, 32'h1234_5678);
    @(negedge clk);

    // Write, then a back-to-back read issued as soon as RESP ends.
    txn_fwd(32'h3800_0004, 1, 32'hA5A5_A5A5, 4'hF, 3, 32'h0BAD_0BAD, acc);
    first_ack = last_ack;
    txn_fwd(32'h3800_0020, 0, 32'h0, 4'h5, 0, 32'hCAFE_F00D, acc);
    #3;
    chk("b2b_ack_gap", 32'(last_ack - first_ack), 32'd3);
    chk("b2b_data", wbs_dat_o, 32'hCAFE_F00D);
    @(negedge clk);

    // Just past the top and just below the bottom of the window.
    txn_oow(32'h3840_0000, 0, acc);
    txn_oow(32'h37FF_FFFC, 0, acc);
    #3;
    chk("oow_latency", 32'(last_ack + 1 - acc), 32'd1);
    chk("oow_err", 32'(err_cnt_o), 32'd2);
    chk("oow_data", wbs_dat_o, 32'd0);
    @(negedge clk);

`ifdef USER_WB_GATE_WATCHDOG_EN
    txn_timeout(32'h3800_0100, acc);
    #3;
    chk("to_latency", 32'(last_ack + 1 - acc), 32'd65);
    chk("to_data", wbs_dat_o, 32'hDEAD_BEEF);
    chk("to_err", 32'(err_cnt_o), 32'd3);
    @(negedge clk);
`endif
    // Slave acks on the watchdog's last cycle: normal completion.
    txn_fwd(32'h3800_0104, 0, 32'h0, 4'hF, TMO - 1, 32'h5EED_0001, acc);
    #3;
    chk("late_latency", 32'(last_ack + 1 - acc), 32'd65);
    chk("late_data", wbs_dat_o, 32'h5EED_0001);
    @(negedge clk);

    txn_abort(32'h3800_0200, 5);
    txn_fwd(32'h3800_0204, 0, 32'h0, 4'hF, 2, 32'h0000_ABCD, acc);
    txn_reset(32'h3800_0300, 4);
    #3;
    chk("rst_fwd_err", 32'(err_cnt_o), 32'd0);
    chk("rst_fwd_dat", wbs_dat_o, 32'd0);
    chk("rst_fwd_mcyc", 32'(m_cyc_o), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 300; i++) txn_oow(32'h0000_1000 + 32'(i * 4), i[0], acc);
    #3;
    chk("sat_err", 32'(err_cnt_o), 32'd255);
    repeat (2) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/user_wb_gate.md
# user_wb_gate

Wishbone request gate between the Caravel management bus and the user-area wait-state BRAM slave. Decodes the user address window, registers and forwards in-window cycles to the slave, returns the slave's data/ack upstream, and answers out-of-window cycles locally. An optional watchdog terminates cycles the slave never acknowledges.

## Interface
- BASE_ADDR, 32'h3800_0000, first byte address of the forwarded window
- WIN_SIZE, 32'h0040_0000, window size in bytes; in-window = BASE_ADDR ≤ adr < BASE_ADDR+WIN_SIZE (unsigned, 33-bit compare, no wrap)
- TIMEOUT, 64, watchdog limit in FWD cycles (2..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream master controls
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  upstream ack, registered
- wbs_dat_o  out  32  upstream read data, registered
- m_cyc_o, m_stb_o, m_we_o  out  1 each  downstream controls, registered
- m_sel_o  out  4; m_adr_o, m_dat_o  out  32  latched request
- m_ack_i  in  1; m_dat_i  in  32  downstream response
- timeout_o  out  1  one-cycle pulse per watchdog termination
- err_cnt_o  out  8  saturating count of timeouts and out-of-window cycles

## Operation
- States: IDLE, FWD, RESP.
- IDLE: request = wbs_cyc_i & wbs_stb_i.
  - In-window request: latch adr/dat/sel/we into m_* regs, m_cyc_o=m_stb_o=1 from next cycle, go FWD, clear watchdog counter.
  - Out-of-window request: wbs_dat_o←0, writes discarded, err_cnt_o+1 (saturate at 255), go RESP.
- FWD: m_* held stable; counter +1 per cycle.
  - m_ack_i=1: wbs_dat_o←m_dat_i (writes: also captured, value don't-care), m_cyc_o/m_stb_o←0, go RESP.
  - wbs_cyc_i=0 (master abort): m_cyc_o/m_stb_o←0, go IDLE, no upstream ack.
  - Watchdog (macro on): counter == TIMEOUT-1 with no m_ack_i: m_cyc_o/m_stb_o←0, wbs_dat_o←ERR_DATA, timeout_o pulse, err_cnt_o+1, go RESP. m_ack_i in that same cycle wins (normal completion).
- RESP: wbs_ack_o=1 for exactly this cycle; go IDLE. New request accepted in IDLE the following cycle (no dead cycle beyond RESP).
- m_ack_i outside FWD ignored. Upstream inputs ignored outside IDLE except wbs_cyc_i in FWD.
- wbs_dat_o holds last value until next capture.

## Timing
- Reset (sync, takes effect at edge with wb_rst_i=1): state IDLE; all outputs 0 (wbs_ack_o, wbs_dat_o, m_*, timeout_o, err_cnt_o); counter 0. Reset in FWD drops m_cyc_o at that edge; no ack issued.
- In-window: request sampled edge 0 → m_stb_o high from edge 1 → m_ack_i sampled edge k → wbs_ack_o high cycle after edge k. Total upstream latency = slave latency + 2.
- Out-of-window: request edge 0 → wbs_ack_o high after edge 1, i.e. 1 cycle.
- Timeout: wbs_ack_o high TIMEOUT+1 cycles after the IDLE accept edge.

## Configuration
- USER_WB_GATE_WATCHDOG_EN defined: watchdog, timeout_o, and timeout counting in err_cnt_o active.
- Undefined: FWD waits indefinitely for m_ack_i or abort; timeout_o tied 0; err_cnt_o counts only out-of-window cycles; counter logic removed.

## Test plan
- Read adr 32'h3800_0010, slave acks 11 cycles after m_stb_o with 32'h1234_5678 → m_adr_o=32'h3800_0010, wbs_ack_o single pulse 13 cycles after accept, wbs_dat_o=32'h1234_5678.
- Write adr 32'h3800_0004, dat 32'hA5A5_A5A5, sel 4'hF → m_we_o=1, m_dat_o/m_sel_o match, one upstream ack after slave ack; back-to-back second read accepted the cycle after RESP.
- Read adr 32'h3840_0000 and 32'h37FF_FFFC → ack 1 cycle after accept, wbs_dat_o=0, m_cyc_o never asserted, err_cnt_o=2.
- Macro on, TIMEOUT=64, slave never acks → m_stb_o drops, timeout_o pulse, wbs_dat_o=32'hDEAD_BEEF, ack 65 cycles after accept; slave ack on final cycle instead → slave data returned, no timeout.
- Drop wbs_cyc_i mid-FWD → m_cyc_o low next edge, no wbs_ack_o; assert wb_rst_i mid-FWD → all outputs 0 after that edge, err_cnt_o=0.
- 300 out-of-window cycles → err_cnt_o saturates at 255.
